mul_seq: RTL and testbench
==========================

# mul_seq

Iterative 64×64→128-bit integer multiplier sequencer for MUL/UMULH/SMULH. It owns no adder: each cycle it drives the shared combinational `alu`, performing one radix-2 shift-add step through the ALU's ADD operation, and retires the result over a valid/ready handshake. It sits in the execute stage beside the main ALU path and borrows the ALU while busy; the parent muxes ALU inputs using `busy`.

## Interface
- `WORDSIZE`, from `bus.vh` (64): operand/result word width.
- `CNTW`, $clog2(`WORDSIZE`)+1: iteration counter width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  high only in IDLE.
- `in_op`  in  2  `MULOP_MUL` / `MULOP_UMULH` / `MULOP_SMULH`.
- `in_a`, `in_b`  in  `WORDSIZE`  multiplicand / multiplier.
- `out_valid`  out  1  result valid, held until accepted.
- `out_ready`  in  1  consumer accepts.
- `out_res`  out  `WORDSIZE`  low product word (MUL) or high word (UMULH/SMULH).
- `busy`  out  1  sequencer owns the ALU (states MUL, FIXA, FIXB).
- `alu_a`, `alu_b`  out  `WORDSIZE`  ALU operands.
- `alu_op`  out  `ALUOPSIZE`  ALU operation.
- `alu_shamt`  out  `SHAMTSIZE`  always 0.
- `alu_res`  in  `WORDSIZE`  ALU result.
- `alu_flags`  in  `FLAGSIZE`  NZVC; only C (bit 0) is used.

## Operation
- Registers: `mcand` (in_a), `hi`, `lo` (init in_b), `op`, `sa`/`sb` (sign bits of in_a/in_b), `cnt`.
- States: IDLE → MUL → (FIXA → FIXB, SMULH only) → DONE → IDLE.
- IDLE: on in_valid && in_ready, latch operands, hi=0, lo=in_b, cnt=0; go MUL.
- MUL: alu_a=hi, alu_b = lo[0] ? mcand : 0, alu_op=`ALUOP_ADD`. Update {hi,lo} = {C, alu_res, lo} >> 1; cnt++. After `WORDSIZE` updates (cnt reaches `WORDSIZE`): go FIXA if op==SMULH, else DONE.
- FIXA: alu_a=hi, alu_b=mcand, alu_op=`ALUOP_ADD` with negate-B (bit 4) set; if sb, hi=alu_res. Go FIXB.
- FIXB: alu_a=hi, alu_b=lo-independent original in_b (held in a `mplier` register), negate-B ADD; if sa, hi=alu_res. Go DONE.
- DONE: out_valid=1; out_res = (op==MUL) ? lo : hi; on out_ready go IDLE.
- Outside MUL/FIXA/FIXB: alu_a=alu_b=0, alu_op=`ALUOP_ADD`, busy=0.
- Product arithmetic mod 2^128; SMULH correction: hi − (sb?a:0) − (sa?b:0) mod 2^64.
- Reserved op 2'b11 executes as MUL.
- in_valid ignored outside IDLE; no queueing.

## Timing
- Reset: state IDLE; in_ready=1, out_valid=0, busy=0, out_res=0, alu_* = 0 / ADD; all registers 0.
- Accept edge = edge 0. MUL/UMULH: out_valid high after edge `WORDSIZE` (64). SMULH: after edge 66.
- out_valid and out_res stable until out_ready sampled high; in_ready rises the cycle after acceptance edge; back-to-back issue gap ≥1 cycle.
- Reset asserted mid-operation: immediate abort to reset values; no output produced.
- ALU path is combinational within one cycle.

## Configuration
- `MUL_SIGNED_EN` defined: SMULH as above, FIXA/FIXB present, `sa`/`sb`/`mplier` registers present.
- Not defined: FIXA/FIXB and sign registers removed; SMULH executes exactly as UMULH (latency 64).

## Structure
- New header `mulop.vh` beside `aluop.vh`: `MULOPSIZE`=2, `MULOP_MUL`=0, `MULOP_UMULH`=1, `MULOP_SMULH`=2, state encodings. Reuse `bus.vh`, `aluop.vh`, `flags.vh`; negate-B op built as `ALUOP_ADD` | 6'b010000.
- No sub-module; ALU instantiated by parent and shared.

## Test plan
- MUL 3×5 → out_res=15 at edge 64; UMULH same → 0.
- UMULH 0xFFFF_FFFF_FFFF_FFFF² → 0xFFFF_FFFF_FFFF_FFFE; MUL same → 1 (carry path).
- SMULH −2×3 → 0xFFFF_FFFF_FFFF_FFFF at edge 66; SMULH −1×−1 → 0; undefined macro: SMULH −1×−1 → 0xFFFF_FFFF_FFFF_FFFE at edge 64.
- out_ready low 10 cycles in DONE → out_valid/out_res held; in_valid during busy ignored (in_ready=0).
- rst_n low at cycle 30 of a MUL → all outputs at reset values; next request 7×9 → 63.
- Back-to-back requests, busy/alu_op checked each cycle against ADD/negate-B sequence.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - word sizes, ALU/MUL opcodes and sequencer state encodings
package mul_seq_pkg;

  localparam int WORDSIZE  = 64;
  localparam int CNTW      = $clog2(WORDSIZE) + 1;
  localparam int ALUOPSIZE = 6;
  localparam int SHAMTSIZE = 6;
  localparam int FLAGSIZE  = 4;
  localparam int MULOPSIZE = 2;

  // Shared ALU opcodes; bit 4 turns ADD into a + (-b).
  localparam logic [ALUOPSIZE-1:0] ALUOP_ADD    = 6'b000000;
  localparam logic [ALUOPSIZE-1:0] ALUOP_NEGB   = 6'b010000;
  localparam logic [ALUOPSIZE-1:0] ALUOP_ADDNEG = ALUOP_ADD | ALUOP_NEGB;

  localparam logic [MULOPSIZE-1:0] MULOP_MUL   = 2'd0;
  localparam logic [MULOPSIZE-1:0] MULOP_UMULH = 2'd1;
  localparam logic [MULOPSIZE-1:0] MULOP_SMULH = 2'd2;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_FIXA = 3'd2;
  localparam logic [2:0] ST_FIXB = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // UMULH/SMULH return the high word; MUL and the reserved code return the low word.
  function automatic logic returns_high(input logic [MULOPSIZE-1:0] op);
    return (op == MULOP_UMULH) || (op == MULOP_SMULH);
  endfunction

endpackage

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - radix-2 shift-add 64x64 multiplier sequencer driving the shared ALU (MUL_SIGNED_EN enables SMULH correction)
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MULOPSIZE-1:0] in_op,
  input  logic [WORDSIZE-1:0]  in_a,
  input  logic [WORDSIZE-1:0]  in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORDSIZE-1:0]  out_res,
  output logic                 busy,
  output logic [WORDSIZE-1:0]  alu_a,
  output logic [WORDSIZE-1:0]  alu_b,
  output logic [ALUOPSIZE-1:0] alu_op,
  output logic [SHAMTSIZE-1:0] alu_shamt,
  input  logic [WORDSIZE-1:0]  alu_res,
  input  logic [FLAGSIZE-1:0]  alu_flags
);

  logic [2:0]           state;
  logic [WORDSIZE-1:0]  mcand;
  logic [WORDSIZE-1:0]  hi;
  logic [WORDSIZE-1:0]  lo;
  logic [MULOPSIZE-1:0] op;
  logic [CNTW-1:0]      cnt;
  logic                 carry;
  logic                 unused_flags;

`ifdef MUL_SIGNED_EN
  logic                 sa;
  logic                 sb;
  logic [WORDSIZE-1:0]  mplier;
`endif

  assign carry        = alu_flags[0];
  assign unused_flags = ^alu_flags[FLAGSIZE-1:1];

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_MUL) || (state == ST_FIXA) || (state == ST_FIXB);
  assign alu_shamt = '0;
  assign out_res   = (state == ST_DONE) ? (returns_high(op) ? hi : lo) : '0;

  // ALU operand steering: shift-add step in MUL, subtract corrections in FIXA/FIXB.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALUOP_ADD;
    case (state)
      ST_MUL: begin
        alu_a = hi;
        alu_b = lo[0] ? mcand : '0;
      end
`ifdef MUL_SIGNED_EN
      ST_FIXA: begin
        alu_a  = hi;
        alu_b  = mcand;
        alu_op = ALUOP_ADDNEG;
      end
      ST_FIXB: begin
        alu_a  = hi;
        alu_b  = mplier;
        alu_op = ALUOP_ADDNEG;
      end
`endif
      default: ;
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      op    <= '0;
      cnt   <= '0;
`ifdef MUL_SIGNED_EN
      sa     <= 1'b0;
      sb     <= 1'b0;
      mplier <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mcand <= in_a;
            hi    <= '0;
            lo    <= in_b;
            op    <= in_op;
            cnt   <= '0;
`ifdef MUL_SIGNED_EN
            sa     <= in_a[WORDSIZE-1];
            sb     <= in_b[WORDSIZE-1];
            mplier <= in_b;
`endif
            state <= ST_MUL;
          end
        end
        ST_MUL: begin
          // {hi,lo} <= {carry, sum, lo} >> 1: the consumed multiplier bit falls off lo.
          hi  <= {carry, alu_res[WORDSIZE-1:1]};
          lo  <= {alu_res[0], lo[WORDSIZE-1:1]};
          cnt <= cnt + CNTW'(1);
          if (cnt == CNTW'(WORDSIZE - 1)) begin
`ifdef MUL_SIGNED_EN
            state <= (op == MULOP_SMULH) ? ST_FIXA : ST_DONE;
`else
            state <= ST_DONE;
`endif
          end
        end
`ifdef MUL_SIGNED_EN
        ST_FIXA: begin
          if (sb) hi <= alu_res;
          state <= ST_FIXB;
        end
        ST_FIXB: begin
          if (sa) hi <= alu_res;
          state <= ST_DONE;
        end
`endif
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - randomized scoreboard bench for mul_seq with a behavioural ALU and product model
module tb_mul_seq;
  import mul_seq_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [MULOPSIZE-1:0] in_op;
  logic [WORDSIZE-1:0]  in_a;
  logic [WORDSIZE-1:0]  in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORDSIZE-1:0]  out_res;
  logic                 busy;
  logic [WORDSIZE-1:0]  alu_a;
  logic [WORDSIZE-1:0]  alu_b;
  logic [ALUOPSIZE-1:0] alu_op;
  logic [SHAMTSIZE-1:0] alu_shamt;
  logic [WORDSIZE-1:0]  alu_res;
  logic [FLAGSIZE-1:0]  alu_flags;
  logic [WORDSIZE:0]    alu_sum;

  typedef struct {
    logic [WORDSIZE-1:0] res;
    int                  acc;
    int                  lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   prev_valid = 1'b0;

  mul_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .alu_res(alu_res), .alu_flags(alu_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared ALU: plain add, or a - b when the negate-B opcode is presented.
  always_comb begin
    alu_sum   = {1'b0, alu_a} + ((alu_op == ALUOP_ADDNEG) ? ({1'b0, ~alu_b} + 65'd1) : {1'b0, alu_b});
    alu_res   = alu_sum[WORDSIZE-1:0];
    alu_flags = {alu_sum[WORDSIZE-1], (alu_sum[WORDSIZE-1:0] == '0), 1'b0, alu_sum[WORDSIZE]};
  end

  function automatic logic [WORDSIZE-1:0] model(input logic [WORDSIZE-1:0] a, b,
                                                input logic [MULOPSIZE-1:0] op);
    logic [2*WORDSIZE-1:0] pu;
    logic [2*WORDSIZE-1:0] ps;
    pu = {{WORDSIZE{1'b0}}, a} * {{WORDSIZE{1'b0}}, b};
    ps = {{WORDSIZE{a[WORDSIZE-1]}}, a} * {{WORDSIZE{b[WORDSIZE-1]}}, b};
    case (op)
      2'd1: return pu[2*WORDSIZE-1:WORDSIZE];
`ifdef MUL_SIGNED_EN
      2'd2: return ps[2*WORDSIZE-1:WORDSIZE];
`else
      2'd2: return pu[2*WORDSIZE-1:WORDSIZE];
`endif
      default: return pu[WORDSIZE-1:0];
    endcase
  endfunction

  function automatic int latency(input logic [MULOPSIZE-1:0] op);
`ifdef MUL_SIGNED_EN
    return (op == 2'd2) ? WORDSIZE + 2 : WORDSIZE;
`else
    return (op == 2'd2) ? WORDSIZE : WORDSIZE;
`endif
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: reset values, per-cycle ALU ownership, and scoreboard compare of results.
  always @(negedge clk) begin
    bit exp_busy;
    bit exp_neg;
    int k;
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_res", out_res, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_op", alu_op, ALUOP_ADD);
      q.delete();
      prev_valid = 1'b0;
    end else begin
      exp_busy = 1'b0;
      exp_neg  = 1'b0;
      if (q.size() > 0 && cyc >= q[0].acc) begin
        k = cyc - q[0].acc;
        exp_busy = (k < q[0].lat);
        exp_neg  = (k >= WORDSIZE) && (k < q[0].lat);
      end
      chk("busy", busy, exp_busy);
      chk("alu_op", alu_op, exp_neg ? ALUOP_ADDNEG : ALUOP_ADD);
      chk("alu_shamt", alu_shamt, 0);
      chk("in_ready", in_ready, !(q.size() > 0 && cyc >= q[0].acc));
      if (!exp_busy) chk("alu_ab_idle", {alu_a, alu_b}, 0);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 0);
        end else begin
          if (!prev_valid) chk("latency", cyc - q[0].acc, q[0].lat);
          chk("out_res", out_res, q[0].res);
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic issue(input logic [WORDSIZE-1:0] a, input logic [WORDSIZE-1:0] b,
                       input logic [MULOPSIZE-1:0] op);
    exp_t e;
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      $display("FAIL issue_timeout: in_ready stayed 0 expected 1");
      $fatal(1, "issue timeout");
    end
    e.res = model(a, b, op);
    e.acc = cyc + 1;
    e.lat = latency(op);
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
  endtask

  task automatic wait_done(input bit rnd_ready);
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    if (q.size() != 0) begin
      $display("FAIL result_timeout: pending=%0d expected 0", q.size());
      $fatal(1, "result timeout");
    end
  endtask

  initial begin
    int n;
    logic [WORDSIZE-1:0] ra;
    logic [WORDSIZE-1:0] rb;
    logic [WORDSIZE-1:0] ones;
    logic [WORDSIZE-1:0] corner [4];
    ones = '1;
    corner[0] = '0;
    corner[1] = ones;
    corner[2] = {1'b1, {(WORDSIZE-1){1'b0}}};
    corner[3] = {1'b0, {(WORDSIZE-1){1'b1}}};
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_op = '0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    issue(64'd3, 64'd5, MULOP_MUL);           wait_done(0);
    issue(64'd3, 64'd5, MULOP_UMULH);         wait_done(0);
    issue(ones, ones, MULOP_UMULH);           wait_done(0);
    issue(ones, ones, MULOP_MUL);             wait_done(0);
    issue(-64'sd2, 64'd3, MULOP_SMULH);       wait_done(0);
    issue(ones, ones, MULOP_SMULH);           wait_done(0);
    issue(64'd11, 64'd13, 2'b11);             wait_done(0);

    // Stray requests while busy must be ignored.
    issue(64'd1234567, 64'd7654321, MULOP_MUL);
    repeat (5) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_a = {$urandom, $urandom};
      in_op = MULOP_UMULH;
    end
    @(posedge clk); #1 in_valid = 1'b0;
    wait_done(0);

    // Consumer stalls 10 cycles in DONE.
    out_ready = 1'b0;
    issue(corner[2], 64'd3, MULOP_SMULH);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (10) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(0);

    // Reset mid-operation, then a fresh request.
    issue(64'd99, 64'd77, MULOP_MUL);
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    issue(64'd7, 64'd9, MULOP_MUL);           wait_done(0);

    for (int i = 0; i < 16; i++) begin
      issue(corner[i % 4], corner[(i / 4) % 4], 2'(i % 3));
      wait_done(1);
    end
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      issue(ra, rb, 2'($urandom_range(0, 3)));
      wait_done(1);
    end

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
